// File: rtl/pa_risc_pkg.sv
// Shared definitions for the pipeline registers: control bus layout,
// NOP control constant and the RAM_CTRL / COMB encodings.
package pa_risc_pkg;

  localparam int RDF_W  = 2;
  localparam int SOH_W  = 3;
  localparam int ALU_W  = 4;
  localparam int RAM_W  = 4;
  localparam int SR_W   = 2;
  localparam int COMB_W = 2;

  // Decoded control bus. All-zero means NOP: no RF, RAM or PSW write.
  typedef struct packed {
    logic              sh;
    logic              bl;
    logic              l;
    logic              rf_le;
    logic              psw_en;
    logic              co_en;
    logic [RDF_W-1:0]  rd_f;
    logic [SOH_W-1:0]  soh_op;
    logic [ALU_W-1:0]  alu_op;
    logic [RAM_W-1:0]  ram_ctrl;
    logic [SR_W-1:0]   id_sr;
    logic [COMB_W-1:0] comb;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

  // RAM_CTRL: [1:0] = 01 load, 11 store, 00 idle; [3:2] = size.
  localparam logic [RAM_W-1:0] RAM_NONE = 4'b0000;
  localparam logic [RAM_W-1:0] RAM_LB   = 4'b0001;
  localparam logic [RAM_W-1:0] RAM_SB   = 4'b0011;
  localparam logic [RAM_W-1:0] RAM_SH   = 4'b0111;
  localparam logic [RAM_W-1:0] RAM_SW   = 4'b1011;

  // COMB: [1] = compare-and-branch, [0] = false-sense.
  localparam logic [COMB_W-1:0] COMB_NONE = 2'b00;
  localparam logic [COMB_W-1:0] COMB_T    = 2'b10;
  localparam logic [COMB_W-1:0] COMB_F    = 2'b11;

  function automatic logic is_store(input logic [RAM_W-1:0] rc);
    return rc[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/ctrl_bus_reg.sv
// Control-bus register with clear / hold / load.
// Ports: i_clk, i_rst_n (async low), i_clr (load NOP, wins over hold),
//        i_hold (keep current value), i_d (next bus), o_q (registered bus).
module ctrl_bus_reg
  import pa_risc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_hold,
  input  logic [CTRL_W-1:0] i_d,
  output logic [CTRL_W-1:0] o_q
);

  logic [CTRL_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_q <= CTRL_NOP;
    else if (i_clr)  r_q <= CTRL_NOP;
    else if (!i_hold) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register. Latches decoded control, operands, destination,
// instruction word and PC; supports stall hold, hazard bubble and flush.
// Ports: i_clk, i_rst_n (async low), i_le (0 = stall), i_hz_bubble,
//        i_flush, i_id_valid, i_id_* (decode outputs), o_ex_* (registered
//        copies), o_ex_valid, o_stall_cnt (saturating stall-cycle count).
module id_ex_pipeline_reg
  import pa_risc_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_le,
  input  logic            i_hz_bubble,
  input  logic            i_flush,
  input  logic            i_id_valid,
  input  logic            i_id_sh,
  input  logic            i_id_bl,
  input  logic            i_id_l,
  input  logic            i_id_rf_le,
  input  logic            i_id_psw_en,
  input  logic            i_id_co_en,
  input  logic [1:0]      i_id_rd_f,
  input  logic [2:0]      i_id_soh_op,
  input  logic [3:0]      i_id_alu_op,
  input  logic [3:0]      i_id_ram_ctrl,
  input  logic [1:0]      i_id_id_sr,
  input  logic [1:0]      i_id_comb,
  input  logic [DW-1:0]   i_id_pa,
  input  logic [DW-1:0]   i_id_pb,
  input  logic [RW-1:0]   i_id_rd,
  input  logic [DW-1:0]   i_id_instr,
  input  logic [DW-1:0]   i_id_pc,
  output logic            o_ex_sh,
  output logic            o_ex_bl,
  output logic            o_ex_l,
  output logic            o_ex_rf_le,
  output logic            o_ex_psw_en,
  output logic            o_ex_co_en,
  output logic [1:0]      o_ex_rd_f,
  output logic [2:0]      o_ex_soh_op,
  output logic [3:0]      o_ex_alu_op,
  output logic [3:0]      o_ex_ram_ctrl,
  output logic [1:0]      o_ex_id_sr,
  output logic [1:0]      o_ex_comb,
  output logic [DW-1:0]   o_ex_pa,
  output logic [DW-1:0]   o_ex_pb,
  output logic [RW-1:0]   o_ex_rd,
  output logic [DW-1:0]   o_ex_instr,
  output logic [DW-1:0]   o_ex_pc,
  output logic            o_ex_valid,
  output logic [CNTW-1:0] o_stall_cnt
);

  ctrl_t w_id_ctrl, w_ex_ctrl;
  logic  w_clr, w_stall;

  assign w_id_ctrl = '{sh: i_id_sh, bl: i_id_bl, l: i_id_l, rf_le: i_id_rf_le,
                       psw_en: i_id_psw_en, co_en: i_id_co_en, rd_f: i_id_rd_f,
                       soh_op: i_id_soh_op, alu_op: i_id_alu_op,
                       ram_ctrl: i_id_ram_ctrl, id_sr: i_id_id_sr, comb: i_id_comb};

  // Flush and bubble override a stall; an invalid ID slot loads as NOP so a
  // dead instruction can never carry a store or RF write into EX.
  assign w_clr   = i_flush | i_hz_bubble | (i_le & ~i_id_valid);
  assign w_stall = ~i_flush & ~i_hz_bubble & ~i_le;

  ctrl_bus_reg u_ctrl (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_hold  (~i_le),
    .i_d     (w_id_ctrl),
    .o_q     (w_ex_ctrl)
  );

  logic [DW-1:0]   r_pa, r_pb, r_instr, r_pc;
  logic [RW-1:0]   r_rd;
  logic            r_valid;
  logic [CNTW-1:0] r_stall_cnt;

  // Data fields are don't-care under flush/bubble, so they only hold on a
  // genuine stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pa    <= '0;
      r_pb    <= '0;
      r_rd    <= '0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (!w_stall) begin
      r_pa    <= i_id_pa;
      r_pb    <= i_id_pb;
      r_rd    <= i_id_rd;
      r_instr <= i_id_instr;
      r_pc    <= i_id_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_valid <= 1'b0;
    else if (i_flush | i_hz_bubble)  r_valid <= 1'b0;
    else if (i_le)                   r_valid <= i_id_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNTW{1'b1}})) r_stall_cnt <= r_stall_cnt + CNTW'(1);
  end

  assign o_ex_sh       = w_ex_ctrl.sh;
  assign o_ex_bl       = w_ex_ctrl.bl;
  assign o_ex_l        = w_ex_ctrl.l;
  assign o_ex_rf_le    = w_ex_ctrl.rf_le;
  assign o_ex_psw_en   = w_ex_ctrl.psw_en;
  assign o_ex_co_en    = w_ex_ctrl.co_en;
  assign o_ex_rd_f     = w_ex_ctrl.rd_f;
  assign o_ex_soh_op   = w_ex_ctrl.soh_op;
  assign o_ex_alu_op   = w_ex_ctrl.alu_op;
  assign o_ex_ram_ctrl = w_ex_ctrl.ram_ctrl;
  assign o_ex_id_sr    = w_ex_ctrl.id_sr;
  assign o_ex_comb     = w_ex_ctrl.comb;
  assign o_ex_pa       = r_pa;
  assign o_ex_pb       = r_pb;
  assign o_ex_rd       = r_rd;
  assign o_ex_instr    = r_instr;
  assign o_ex_pc       = r_pc;
  assign o_ex_valid    = r_valid;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;
  import pa_risc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, le, hz, flush, idv;
  ctrl_t ic;
  logic [31:0] pa, pb, instr, pc;
  logic [4:0]  rd;

  // main DUT (CNTW=16) and a CNTW=4 copy for saturation
  ctrl_t oc, oc4;
  logic [31:0] o_pa, o_pb, o_instr, o_pc, d_pa, d_pb, d_instr, d_pc;
  logic [4:0]  o_rd, d_rd;
  logic        o_v, d_v;
  logic [15:0] o_cnt;
  logic [3:0]  d_cnt;

  id_ex_pipeline_reg #(.DW(32), .RW(5), .CNTW(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_le(le), .i_hz_bubble(hz), .i_flush(flush),
    .i_id_valid(idv), .i_id_sh(ic.sh), .i_id_bl(ic.bl), .i_id_l(ic.l),
    .i_id_rf_le(ic.rf_le), .i_id_psw_en(ic.psw_en), .i_id_co_en(ic.co_en),
    .i_id_rd_f(ic.rd_f), .i_id_soh_op(ic.soh_op), .i_id_alu_op(ic.alu_op),
    .i_id_ram_ctrl(ic.ram_ctrl), .i_id_id_sr(ic.id_sr), .i_id_comb(ic.comb),
    .i_id_pa(pa), .i_id_pb(pb), .i_id_rd(rd), .i_id_instr(instr), .i_id_pc(pc),
    .o_ex_sh(oc.sh), .o_ex_bl(oc.bl), .o_ex_l(oc.l), .o_ex_rf_le(oc.rf_le),
    .o_ex_psw_en(oc.psw_en), .o_ex_co_en(oc.co_en), .o_ex_rd_f(oc.rd_f),
    .o_ex_soh_op(oc.soh_op), .o_ex_alu_op(oc.alu_op), .o_ex_ram_ctrl(oc.ram_ctrl),
    .o_ex_id_sr(oc.id_sr), .o_ex_comb(oc.comb), .o_ex_pa(o_pa), .o_ex_pb(o_pb),
    .o_ex_rd(o_rd), .o_ex_instr(o_instr), .o_ex_pc(o_pc), .o_ex_valid(o_v),
    .o_stall_cnt(o_cnt)
  );

  id_ex_pipeline_reg #(.DW(32), .RW(5), .CNTW(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_le(le), .i_hz_bubble(hz), .i_flush(flush),
    .i_id_valid(idv), .i_id_sh(ic.sh), .i_id_bl(ic.bl), .i_id_l(ic.l),
    .i_id_rf_le(ic.rf_le), .i_id_psw_en(ic.psw_en), .i_id_co_en(ic.co_en),
    .i_id_rd_f(ic.rd_f), .i_id_soh_op(ic.soh_op), .i_id_alu_op(ic.alu_op),
    .i_id_ram_ctrl(ic.ram_ctrl), .i_id_id_sr(ic.id_sr), .i_id_comb(ic.comb),
    .i_id_pa(pa), .i_id_pb(pb), .i_id_rd(rd), .i_id_instr(instr), .i_id_pc(pc),
    .o_ex_sh(oc4.sh), .o_ex_bl(oc4.bl), .o_ex_l(oc4.l), .o_ex_rf_le(oc4.rf_le),
    .o_ex_psw_en(oc4.psw_en), .o_ex_co_en(oc4.co_en), .o_ex_rd_f(oc4.rd_f),
    .o_ex_soh_op(oc4.soh_op), .o_ex_alu_op(oc4.alu_op), .o_ex_ram_ctrl(oc4.ram_ctrl),
    .o_ex_id_sr(oc4.id_sr), .o_ex_comb(oc4.comb), .o_ex_pa(d_pa), .o_ex_pb(d_pb),
    .o_ex_rd(d_rd), .o_ex_instr(d_instr), .o_ex_pc(d_pc), .o_ex_valid(d_v),
    .o_stall_cnt(d_cnt)
  );

  typedef struct packed {
    ctrl_t       c;
    logic [31:0] pa, pb, instr, pc;
    logic [4:0]  rd;
    logic        v;
    logic        dk;    // data fields defined (not don't-care after flush/bubble)
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("ctrl", oc, e.c);
    chk("valid", o_v, e.v);
    chk("stall_cnt", o_cnt, e.cnt);
    chk("ctrl4", oc4, e.c);
    chk("valid4", d_v, e.v);
    chk("stall_cnt4", d_cnt, e.cnt4);
    if (e.dk) begin
      chk("pa", o_pa, e.pa);       chk("pb", o_pb, e.pb);
      chk("rd", o_rd, e.rd);       chk("instr", o_instr, e.instr);
      chk("pc", o_pc, e.pc);
      chk("pa4", d_pa, e.pa);      chk("pb4", d_pb, e.pb);
      chk("rd4", d_rd, e.rd);      chk("instr4", d_instr, e.instr);
      chk("pc4", d_pc, e.pc);
    end
    if (is_store(oc.ram_ctrl)) chk("store_needs_valid", o_v, 1'b1);
  endtask

  function automatic exp_t reset_model();
    exp_t r;
    r = '0;
    r.dk = 1'b1;
    return r;
  endfunction

  task automatic step(input logic l, input logic b, input logic f, input logic v,
                      input ctrl_t c, input logic [31:0] a, input logic [31:0] bb,
                      input logic [4:0] r);
    exp_t e;
    le = l; hz = b; flush = f; idv = v; ic = c; pa = a; pb = bb; rd = r;
    instr = a ^ 32'hA5A5_0000; pc = bb + 32'h100;
    if (f || b) begin
      m.c = '0; m.v = 1'b0; m.dk = 1'b0;
    end else if (!l) begin
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      if (m.cnt4 != 4'hF)    m.cnt4 = m.cnt4 + 4'd1;
    end else begin
      m.c = v ? c : '0; m.v = v; m.dk = 1'b1;
      m.pa = a; m.pb = bb; m.rd = r; m.instr = instr; m.pc = pc;
    end
    q.push_back(m);
    @(posedge clk); #1;
    e = q.pop_front();
    compare(e);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m = reset_model();
    compare(m);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ctrl_t c;
    logic [22:0] rv;
    rst_n = 1'b0; le = 1'b1; hz = 1'b0; flush = 1'b0; idv = 1'b0;
    ic = '0; pa = '0; pb = '0; rd = '0; instr = '0; pc = '0;
    m = reset_model();
    repeat (2) @(posedge clk);
    #1 compare(m);
    @(negedge clk) rst_n = 1'b1;

    // ADD load
    c = '0; c.rf_le = 1'b1; c.psw_en = 1'b1; c.alu_op = 4'b0000;
    step(1, 0, 0, 1, c, 32'd5, 32'd7, 5'd3);
    chk("add_alu_op", oc.alu_op, 4'b0000);
    chk("add_rf_le", oc.rf_le, 1'b1);
    chk("add_pa", o_pa, 32'd5);
    chk("add_pb", o_pb, 32'd7);
    chk("add_valid", o_v, 1'b1);

    // stall 3 edges while ID changes
    for (int i = 0; i < 3; i++) begin
      c = '0; c.alu_op = 4'(i + 1); c.bl = 1'b1;
      step(0, 0, 0, 1, c, 32'(100 + i), 32'(200 + i), 5'(i + 8));
    end
    chk("stall_cnt_3", o_cnt, 16'd3);

    // bubble on a store byte, then the real load
    c = '0; c.ram_ctrl = RAM_SB; c.rf_le = 1'b1;
    step(1, 1, 0, 1, c, 32'd9, 32'd10, 5'd4);
    chk("bubble_ram", oc.ram_ctrl, RAM_NONE);
    step(1, 0, 0, 1, c, 32'd9, 32'd10, 5'd4);
    chk("after_bubble_ram", oc.ram_ctrl, RAM_SB);

    // flush beats stall
    c = '0; c.comb = COMB_T; c.co_en = 1'b1;
    step(0, 0, 1, 1, c, 32'd1, 32'd2, 5'd5);
    chk("flush_stall_cnt", o_cnt, 16'd3);
    // bubble with le=0
    step(0, 1, 0, 1, c, 32'd3, 32'd4, 5'd6);
    // invalid ID loads NOP
    c = '0; c.ram_ctrl = RAM_SW; c.rf_le = 1'b1; c.l = 1'b1; c.sh = 1'b1;
    step(1, 0, 0, 0, c, 32'd11, 32'd12, 5'd7);
    // branch-type load
    c = '0; c.comb = COMB_F; c.bl = 1'b1; c.ram_ctrl = RAM_LB; c.soh_op = 3'd5;
    step(1, 0, 0, 1, c, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      rv = 23'($urandom);
      c = rv;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
           c, $urandom, $urandom, 5'($urandom));
    end

    // reset mid-operation, first edge after release is a load
    mid_reset();
    c = '0; c.psw_en = 1'b1; c.alu_op = 4'd9;
    step(1, 0, 0, 1, c, 32'd77, 32'd88, 5'd2);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, c, 32'(i), 32'(i), 5'd1);
    chk("sat_cnt4", d_cnt, 4'hF);
    chk("cnt16_20", o_cnt, 16'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
